// File: rtl/light_fsm_if.sv
// Turn-request / lamp-drive bundle between the switch logic and the
// tail-light sequencer. The sequencer is the slave: it samples the
// requests and drives the six lamp lines.
interface light_fsm_if;
  logic left;   // left-turn request, level-sensitive
  logic right;  // right-turn request, level-sensitive
  logic la;     // left lamp A (inner)
  logic lb;     // left lamp B
  logic lc;     // left lamp C (outer)
  logic ra;     // right lamp A (inner)
  logic rb;     // right lamp B
  logic rc;     // right lamp C (outer)

  // Switch-logic side: issues requests, observes lamps.
  modport master (
    output left, right,
    input  la, lb, lc, ra, rb, rc
  );

  // Sequencer side: samples requests, drives lamps.
  modport slave (
    input  left, right,
    output la, lb, lc, ra, rb, rc
  );
endinterface

// File: rtl/light_fsm.sv
// Tail-light sequencer: a Moore machine that chases three lamps outward on
// the requested side, or flashes all six lamps when both sides are requested.
// Lamp outputs come straight from flops so they never glitch between edges.
module light_fsm (
  input  logic        clk,
  input  logic        reset,     // synchronous, active-low
  light_fsm_if.slave  lamp_if
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    L1   = 3'd1,
    L2   = 3'd2,
    L3   = 3'd3,
    R1   = 3'd4,
    R2   = 3'd5,
    R3   = 3'd6,
    HAZ  = 3'd7
  } state_e;

  // Lamp vector order: {la, lb, lc, ra, rb, rc}
  localparam logic [5:0] LAMPS_OFF = 6'b000000;
  localparam logic [5:0] LAMPS_L1  = 6'b100000;
  localparam logic [5:0] LAMPS_L2  = 6'b110000;
  localparam logic [5:0] LAMPS_L3  = 6'b111000;
  localparam logic [5:0] LAMPS_R1  = 6'b000100;
  localparam logic [5:0] LAMPS_R2  = 6'b000110;
  localparam logic [5:0] LAMPS_R3  = 6'b000111;
  localparam logic [5:0] LAMPS_HAZ = 6'b111111;

  state_e     state_q, state_d;
  logic [5:0] lamps_q, lamps_d;

  // State and lamp registers; synchronous reset forces IDLE with all lamps dark.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      lamps_q <= LAMPS_OFF;
    end else begin
      state_q <= state_d;
      lamps_q <= lamps_d;
    end
  end

  // Next-state selection, then lamp decode of that next state so the lamp
  // flops always hold the pattern belonging to state_q.
  // NOTE: every variable gets a default before the case statements; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    state_d = IDLE;
    lamps_d = LAMPS_OFF;

    case (state_q)
      IDLE: begin
        if (lamp_if.left && lamp_if.right) state_d = HAZ;
        else if (lamp_if.left)             state_d = L1;
        else if (lamp_if.right)            state_d = R1;
        else                               state_d = IDLE;
      end
      // Chase steps ignore the inputs until the sequence is done.
      L1:      state_d = L2;
      L2:      state_d = L3;
      L3:      state_d = IDLE;
      R1:      state_d = R2;
      R2:      state_d = R3;
      R3:      state_d = IDLE;
      HAZ:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    case (state_d)
      L1:      lamps_d = LAMPS_L1;
      L2:      lamps_d = LAMPS_L2;
      L3:      lamps_d = LAMPS_L3;
      R1:      lamps_d = LAMPS_R1;
      R2:      lamps_d = LAMPS_R2;
      R3:      lamps_d = LAMPS_R3;
      HAZ:     lamps_d = LAMPS_HAZ;
      default: lamps_d = LAMPS_OFF;
    endcase
  end

  assign lamp_if.la = lamps_q[5];
  assign lamp_if.lb = lamps_q[4];
  assign lamp_if.lc = lamps_q[3];
  assign lamp_if.ra = lamps_q[2];
  assign lamp_if.rb = lamps_q[1];
  assign lamp_if.rc = lamps_q[0];

endmodule

// File: tb/tb_light_fsm.sv
// Self-checking bench for the tail-light sequencer. Directed scenarios are
// checked against literal lamp tables and a reference model; a random phase
// is checked against the model alone. The model describes behaviour as a
// queue of pending lamp patterns: when the queue is empty the machine is
// idle and looks at the requests, otherwise it plays out the queue.
module tb_light_fsm;

  logic clk = 1'b0;
  logic reset;

  light_fsm_if lamp_bus ();

  light_fsm dut (
    .clk     (clk),
    .reset   (reset),
    .lamp_if (lamp_bus.slave)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;

  logic [5:0] pend[$];
  logic [5:0] exp_v;
  logic [5:0] lamps;

  assign lamps = {lamp_bus.la, lamp_bus.lb, lamp_bus.lc,
                  lamp_bus.ra, lamp_bus.rb, lamp_bus.rc};

  // Drive one cycle of inputs, let one rising edge pass, advance the model,
  // and return 1 time unit after the edge for sampling.
  task automatic tick(input logic l, input logic r, input logic rst);
    lamp_bus.left  = l;
    lamp_bus.right = r;
    reset          = rst;
    @(posedge clk);
    cycle++;
    if (!rst) begin
      pend.delete();
      exp_v = 6'b000000;
    end else if (pend.size() > 0) begin
      exp_v = pend.pop_front();
    end else if (l && r) begin
      exp_v = 6'b111111;
      pend.push_back(6'b000000);
    end else if (l) begin
      exp_v = 6'b100000;
      pend  = '{6'b110000, 6'b111000, 6'b000000};
    end else if (r) begin
      exp_v = 6'b000100;
      pend  = '{6'b000110, 6'b000111, 6'b000000};
    end else begin
      exp_v = 6'b000000;
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      tick(1'b1, 1'b1, 1'b0);
      checks++;
      if (lamps !== 6'b000000) begin
        failures++;
        $display("FAIL reset_hold cycle %0d: got %b expected %b", cycle, lamps, 6'b000000);
      end
    end
    for (int i = 0; i < 2; i++) begin
      tick(1'b0, 1'b0, 1'b1);
      checks++;
      if (lamps !== 6'b000000 || lamps !== exp_v) begin
        failures++;
        $display("FAIL reset_release cycle %0d: got %b expected %b", cycle, lamps, exp_v);
      end
    end
  endtask

  task automatic test_left();
    logic [5:0] tbl [8];
    tbl = '{6'b100000, 6'b110000, 6'b111000, 6'b000000,
            6'b100000, 6'b110000, 6'b111000, 6'b000000};
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, 1'b0, 1'b1);
      checks++;
      if (lamps !== tbl[i] || lamps !== exp_v) begin
        failures++;
        $display("FAIL left_turn step %0d: got %b expected %b", i, lamps, tbl[i]);
      end
    end
  endtask

  task automatic test_right();
    logic [5:0] tbl [6];
    tbl = '{6'b000100, 6'b000110, 6'b000111, 6'b000000, 6'b000000, 6'b000000};
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, (i == 0), 1'b1);
      checks++;
      if (lamps !== tbl[i] || lamps !== exp_v) begin
        failures++;
        $display("FAIL right_pulse step %0d: got %b expected %b", i, lamps, tbl[i]);
      end
    end
  endtask

  task automatic test_hazard();
    logic [5:0] tbl [4];
    tbl = '{6'b111111, 6'b000000, 6'b111111, 6'b000000};
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 1'b1, 1'b1);
      checks++;
      if (lamps !== tbl[i] || lamps !== exp_v) begin
        failures++;
        $display("FAIL hazard step %0d: got %b expected %b", i, lamps, tbl[i]);
      end
    end
    tick(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_mid_switch();
    logic [5:0] tbl [9];
    tbl = '{6'b100000, 6'b110000, 6'b111000, 6'b000000, 6'b000100,
            6'b000110, 6'b000111, 6'b000000, 6'b000000};
    for (int i = 0; i < 9; i++) begin
      tick((i == 0), (i >= 1 && i <= 4), 1'b1);
      checks++;
      if (lamps !== tbl[i] || lamps !== exp_v) begin
        failures++;
        $display("FAIL mid_switch step %0d: got %b expected %b", i, lamps, tbl[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [5:0] tbl [8];
    logic       l_v [8];
    logic       r_v [8];
    logic       rst_v [8];
    tbl   = '{6'b100000, 6'b110000, 6'b000000, 6'b000000,
              6'b000100, 6'b000110, 6'b000111, 6'b000000};
    l_v   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    r_v   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    rst_v = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 8; i++) begin
      tick(l_v[i], r_v[i], rst_v[i]);
      checks++;
      if (lamps !== tbl[i] || lamps !== exp_v) begin
        failures++;
        $display("FAIL reset_mid step %0d: got %b expected %b", i, lamps, tbl[i]);
      end
    end
  endtask

  task automatic test_random();
    logic l, r, rst;
    for (int i = 0; i < 400; i++) begin
      l   = 1'($urandom_range(0, 1));
      r   = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 19) != 0);
      tick(l, r, rst);
      checks++;
      if (lamps !== exp_v) begin
        failures++;
        $display("FAIL random cycle %0d (l=%b r=%b rst=%b): got %b expected %b",
                 cycle, l, r, rst, lamps, exp_v);
      end
    end
  endtask

  initial begin
    lamp_bus.left  = 1'b0;
    lamp_bus.right = 1'b0;
    reset          = 1'b0;
    exp_v          = 6'b000000;
    @(negedge clk);
    test_reset();
    test_left();
    test_right();
    test_hazard();
    test_mid_switch();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/light_fsm.md
# light_fsm

Tail-light sequencer for a vehicle rear-lamp cluster with three lamps per side (A inner, B middle, C outer). A turn request starts a three-step chase that lights lamps progressively outward, then blanks. Simultaneous left and right requests produce a hazard flash instead. The block is a single-clock Moore state machine sitting between the turn-signal switch logic and the lamp drivers.

## Interface
- No parameters.
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-low; sampled on the rising edge of clk.
- left  input  1  left-turn request, level-sensitive, sampled each rising edge.
- right  input  1  right-turn request, level-sensitive, sampled each rising edge.
- la, lb, lc  output  1 each  left lamps A (inner), B, C (outer); 1 = lit.
- ra, rb, rc  output  1 each  right lamps A (inner), B, C (outer); 1 = lit.
- Output vector notation used below: {la,lb,lc,ra,rb,rc}.

## Operation
- Moore machine: outputs decode from the registered state only, never directly from left/right.
- States and outputs:
  - IDLE: 000000
  - L1: 100000; L2: 110000; L3: 111000
  - R1: 000100; R2: 000110; R3: 000111
  - HAZ: 111111
- Transitions, evaluated on each rising edge with reset high:
  - IDLE: left=1,right=1 -> HAZ; left=1,right=0 -> L1; left=0,right=1 -> R1; neither -> IDLE.
  - L1 -> L2 -> L3 -> IDLE unconditionally. Inputs are ignored until the sequence completes.
  - R1 -> R2 -> R3 -> IDLE unconditionally.
  - HAZ -> IDLE unconditionally. Held hazard input therefore flashes all lamps: 1 cycle on, 1 cycle off.
- A request held continuously repeats the sequence every 4 cycles: L1, L2, L3, IDLE, L1, ...
- A request asserted for a single cycle while in IDLE launches the full sequence.
- A request arriving mid-sequence is not latched. It only takes effect if it is still asserted when the machine is in IDLE.
- Reset has priority over all transitions. Reset low on a rising edge forces IDLE, which clears all outputs, from any state including mid-sequence or HAZ.
- Encoding is free. Any unreachable encodings must return to IDLE on the next edge.

## Timing
- Reset value: state IDLE, all six outputs 0, effective after the first rising edge with reset=0.
- First edge with reset=1: state leaves IDLE if a request is present.
- Latency: a request sampled at edge N gives the first lamp output after edge N. Full sequence = 3 lit cycles + 1 dark cycle.
- Outputs are glitch-free between edges. They change only after a rising clk edge.
- Inputs may change at any time between edges; only the value at the rising edge matters.

## Test plan
- Reset: hold reset=0 for 2 edges with left=1,right=1 -> outputs 000000 throughout. Release with no request -> remains 000000.
- Left turn: left=1,right=0 held for 8 cycles -> 100000, 110000, 111000, 000000, 100000, 110000, 111000, 000000.
- Right turn: right=1 for 1 cycle then 0 -> 000100, 000110, 000111, 000000, then stays 000000.
- Hazard: left=1,right=1 held for 4 cycles -> 111111, 000000, 111111, 000000.
- Mid-sequence switch: left=1 for one cycle, then right=1 during L1/L2 and held -> 100000, 110000, 111000, 000000, 000100.
- Reset mid-operation: reset=0 while in L2 (110000) -> 000000 after that edge. After reset returns to 1, the next request starts cleanly at L1/R1.
